// File: rtl/clapper_pkg.sv
// Shared types and constants for the clapper light controller.
package clapper_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DECODE,
        CLEAR
    } state_t;

    typedef enum logic [1:0] {
        CMD_REJECT = 2'd0,
        CMD_TOGGLE = 2'd1,
        CMD_ON     = 2'd2,
        CMD_OFF    = 2'd3
    } cmd_t;

    localparam logic [3:0] TOGGLE_CLAPS = 4'd2;
    localparam logic [3:0] ON_CLAPS     = 4'd3;
    localparam logic [3:0] OFF_CLAPS    = 4'd4;

    function automatic cmd_t decode_claps(input logic [3:0] n);
        cmd_t c;
        unique case (1'b1)
            (n == TOGGLE_CLAPS): c = CMD_TOGGLE;
            (n == ON_CLAPS):     c = CMD_ON;
            (n == OFF_CLAPS):    c = CMD_OFF;
            default:             c = CMD_REJECT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/clap_window_timer.sv
// Saturating up-counter; tc is high once the count has reached TERM.
module clap_window_timer #(
    parameter int W    = 8,
    parameter int TERM = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != '1) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count >= W'(TERM));

endmodule

// File: rtl/clap_command_decoder.sv
// Ends a clap burst on quiet gap or window cap, decodes it and clears the counter.
module clap_command_decoder
    import clapper_pkg::*;
#(
    parameter int SETTLE_CYCLES     = 25_000_000,
    parameter int MAX_WINDOW_CYCLES = 100_000_000,
    parameter int CLR_CYCLES        = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] clapCount,
    output logic       counterClr,
    output logic       cmdValid,
    output logic [1:0] cmdCode,
    output logic       lightOn,
    output logic       busy
);

    localparam int TW = $clog2(MAX_WINDOW_CYCLES);
    localparam int CW = $clog2(CLR_CYCLES + 1);

    state_t        state;
    logic [3:0]    last_count;
    logic [CW-1:0] clr_cnt;
    logic          change;
    logic          quiet_tc;
    logic          win_tc;
    logic          in_idle;
    logic          in_collect;
    cmd_t          dec_cmd;

    assign change     = (clapCount != last_count);
    assign in_idle    = (state == IDLE);
    assign in_collect = (state == COLLECT);
    assign dec_cmd    = decode_claps(clapCount);
    assign busy       = !in_idle;

    // Terminals sit two below the cycle counts: one cycle is spent in the
    // clear that starts the count, one in the transition to DECODE.
    clap_window_timer #(
        .W    (TW),
        .TERM (SETTLE_CYCLES - 2)
    ) u_quiet (
        .clk (clk),
        .rst (rst),
        .clr (in_idle || change),
        .en  (in_collect),
        .tc  (quiet_tc)
    );

    clap_window_timer #(
        .W    (TW),
        .TERM (MAX_WINDOW_CYCLES - 2)
    ) u_window (
        .clk (clk),
        .rst (rst),
        .clr (in_idle),
        .en  (in_collect),
        .tc  (win_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_count <= 4'd0;
            clr_cnt    <= '0;
            counterClr <= 1'b0;
            cmdValid   <= 1'b0;
            cmdCode    <= CMD_REJECT;
            lightOn    <= 1'b0;
        end else begin
            last_count <= clapCount;
            cmdValid   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (change) state <= COLLECT;
                end
                COLLECT: begin
                    if ((quiet_tc && !change) || win_tc) state <= DECODE;
                end
                DECODE: begin
                    cmdValid   <= 1'b1;
                    cmdCode    <= dec_cmd;
                    counterClr <= 1'b1;
                    clr_cnt    <= '0;
                    state      <= CLEAR;
                    unique case (dec_cmd)
                        CMD_TOGGLE: lightOn <= !lightOn;
                        CMD_ON:     lightOn <= 1'b1;
                        CMD_OFF:    lightOn <= 1'b0;
                        default:    lightOn <= lightOn;
                    endcase
                end
                CLEAR: begin
                    if (clr_cnt >= CW'(CLR_CYCLES - 1) && clapCount == 4'd0) begin
                        counterClr <= 1'b0;
                        state      <= IDLE;
                    end else if (clr_cnt != '1) begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
